// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, redirect and
// data-memory wait hazards, with perf counters and a memory-timeout trap.
module pipeline_hazard_ctrl #(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       i_id_rs1_sel,
    input  logic [4:0]       i_id_rs2_sel,
    input  logic             i_id_uses_rs1,
    input  logic             i_id_uses_rs2,
    input  logic [4:0]       i_ex_rd_sel,
    input  logic             i_ex_write_enable,
    input  logic             i_ex_is_load,
    input  logic             i_ex_branch_taken,
    input  logic             i_mem_req,
    input  logic             i_mem_ready,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_ifid_flush,
    output logic             o_idex_en,
    output logic             o_idex_bubble,
    output logic             o_exmem_en,
    output logic             o_trap,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_stall_cycles,
    output logic [CNT_W-1:0] o_flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TRAP     = 2'd2
    } state_t;

    localparam int WW = $clog2(WAIT_MAX + 1);

    state_t           r_state;
    state_t           w_next;
    logic [WW-1:0]    r_wait;
    logic [WW-1:0]    w_wait_nxt;
    logic             r_trap;
    logic [CNT_W-1:0] r_stall;
    logic [CNT_W-1:0] r_flush;

    logic w_load_use;
    logic w_mem_stall;
    logic w_resolve;

    assign w_load_use = i_ex_is_load & i_ex_write_enable & (i_ex_rd_sel != 5'd0)
                      & ((i_id_uses_rs1 & (i_id_rs1_sel == i_ex_rd_sel))
                       | (i_id_uses_rs2 & (i_id_rs2_sel == i_ex_rd_sel)));
    assign w_mem_stall = i_mem_req & ~i_mem_ready;

    always_comb begin
        w_next        = r_state;
        w_wait_nxt    = r_wait;
        w_resolve     = 1'b0;
        o_pc_en       = 1'b0;
        o_ifid_en     = 1'b0;
        o_ifid_flush  = 1'b0;
        o_idex_en     = 1'b0;
        o_idex_bubble = 1'b0;
        o_exmem_en    = 1'b0;
        unique case (r_state)
            RUN: begin
                if (w_mem_stall) begin
                    w_next     = MEM_WAIT;
                    w_wait_nxt = WW'(1);
                end else begin
                    w_resolve = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (i_mem_ready) begin
                    w_resolve  = 1'b1;
                    w_next     = RUN;
                    w_wait_nxt = '0;
                end else if (r_wait == WW'(WAIT_MAX - 1)) begin
                    w_next = TRAP;
                end else begin
                    w_wait_nxt = r_wait + WW'(1);
                end
            end
            TRAP: ;
            default: w_next = TRAP;
        endcase
        // A redirect squashes the ID instruction, so it outranks load-use
        if (w_resolve && rst_n) begin
            if (i_ex_branch_taken) begin
                o_pc_en       = 1'b1;
                o_ifid_en     = 1'b1;
                o_ifid_flush  = 1'b1;
                o_idex_en     = 1'b1;
                o_idex_bubble = 1'b1;
                o_exmem_en    = 1'b1;
            end else if (w_load_use) begin
                o_idex_en     = 1'b1;
                o_idex_bubble = 1'b1;
                o_exmem_en    = 1'b1;
            end else begin
                o_pc_en    = 1'b1;
                o_ifid_en  = 1'b1;
                o_idex_en  = 1'b1;
                o_exmem_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_wait  <= '0;
            r_trap  <= 1'b0;
            r_stall <= '0;
            r_flush <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_nxt;
            if (w_next == TRAP) begin
                r_trap <= 1'b1;
            end
            if (!o_pc_en && (r_stall != '1)) begin
                r_stall <= r_stall + CNT_W'(1);
            end
            if (o_ifid_flush && (r_flush != '1)) begin
                r_flush <= r_flush + CNT_W'(1);
            end
        end
    end

    assign o_trap         = r_trap;
    assign o_state        = r_state;
    assign o_stall_cycles = r_stall;
    assign o_flush_count  = r_flush;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomised and directed bench for pipeline_hazard_ctrl against a
// cycle-level behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

    localparam int WAIT_MAX = 16;
    localparam int CNT_W    = 4;
    localparam int CMAX     = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] id_rs1_sel = '0, id_rs2_sel = '0, ex_rd_sel = '0;
    logic id_uses_rs1 = 0, id_uses_rs2 = 0, ex_we = 0, ex_ld = 0;
    logic ex_br = 0, mem_req = 0, mem_ready = 0;

    logic o_pc_en, o_ifid_en, o_ifid_flush, o_idex_en, o_idex_bubble;
    logic o_exmem_en, o_trap;
    logic [1:0] o_state;
    logic [CNT_W-1:0] o_stall_cycles, o_flush_count;

    int n_cmp = 0;
    int n_bad = 0;

    int m_mode = 0;
    int m_wait = 0;
    int m_stall = 0;
    int m_flush = 0;

    pipeline_hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_id_rs1_sel(id_rs1_sel), .i_id_rs2_sel(id_rs2_sel),
        .i_id_uses_rs1(id_uses_rs1), .i_id_uses_rs2(id_uses_rs2),
        .i_ex_rd_sel(ex_rd_sel), .i_ex_write_enable(ex_we),
        .i_ex_is_load(ex_ld), .i_ex_branch_taken(ex_br),
        .i_mem_req(mem_req), .i_mem_ready(mem_ready),
        .o_pc_en(o_pc_en), .o_ifid_en(o_ifid_en),
        .o_ifid_flush(o_ifid_flush), .o_idex_en(o_idex_en),
        .o_idex_bubble(o_idex_bubble), .o_exmem_en(o_exmem_en),
        .o_trap(o_trap), .o_state(o_state),
        .o_stall_cycles(o_stall_cycles), .o_flush_count(o_flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Expected {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en}
    function automatic logic [5:0] model_ctrl();
        bit hit1, hit2, lu;
        hit1 = id_uses_rs1 && (id_rs1_sel == ex_rd_sel);
        hit2 = id_uses_rs2 && (id_rs2_sel == ex_rd_sel);
        lu = ex_ld && ex_we && (ex_rd_sel != 0) && (hit1 || hit2);
        if (!rst_n || m_mode == 2) return 6'b000000;
        if (m_mode == 1 && !mem_ready) return 6'b000000;
        if (m_mode == 0 && mem_req && !mem_ready) return 6'b000000;
        if (ex_br) return 6'b111111;
        if (lu) return 6'b000111;
        return 6'b110101;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [5:0] e;
        if (!rst_n) begin
            m_mode = 0; m_wait = 0; m_stall = 0; m_flush = 0;
        end else begin
            e = model_ctrl();
            if (!e[5]) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
            if (e[3]) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
            if (m_mode == 0) begin
                if (mem_req && !mem_ready) begin
                    m_mode = 1; m_wait = 1;
                end
            end else if (m_mode == 1) begin
                if (mem_ready) begin
                    m_mode = 0; m_wait = 0;
                end else if (m_wait + 1 >= WAIT_MAX) begin
                    m_mode = 2;
                end else begin
                    m_wait = m_wait + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [5:0] act;
        act = {o_pc_en, o_ifid_en, o_ifid_flush, o_idex_en, o_idex_bubble, o_exmem_en};
        chk("ctrl", int'(act), int'(model_ctrl()));
        chk("state", int'(o_state), m_mode);
        chk("trap", int'(o_trap), (m_mode == 2) ? 1 : 0);
        chk("stall_cycles", int'(o_stall_cycles), m_stall);
        chk("flush_count", int'(o_flush_count), m_flush);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1_sel = 0; id_rs2_sel = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_rd_sel = 0; ex_we = 0; ex_ld = 0; ex_br = 0;
        mem_req = 0; mem_ready = 0;
    endtask

    task automatic set_lw5();
        ex_ld = 1; ex_we = 1; ex_rd_sel = 5;
        id_rs1_sel = 1; id_uses_rs1 = 1;
        id_rs2_sel = 5; id_uses_rs2 = 1;
    endtask

    initial begin
        idle();
        cyc(); cyc();
        @(negedge clk);
        chk("rst_pc_en", int'(o_pc_en), 0);
        chk("rst_state", int'(o_state), 0);
        rst_n = 1;
        cyc();

        set_lw5();
        @(negedge clk);
        chk("lu_pc_en", int'(o_pc_en), 0);
        chk("lu_ifid_en", int'(o_ifid_en), 0);
        chk("lu_bubble", int'(o_idex_bubble), 1);
        cyc();
        ex_ld = 0;
        @(negedge clk);
        chk("lu_release", int'(o_pc_en), 1);
        chk("lu_stall_cnt", int'(o_stall_cycles), 1);
        cyc();

        set_lw5(); ex_rd_sel = 0;
        @(negedge clk);
        chk("x0_no_stall", int'(o_pc_en), 1);
        cyc();
        set_lw5(); id_uses_rs2 = 0;
        @(negedge clk);
        chk("nouse_no_stall", int'(o_pc_en), 1);
        cyc();

        set_lw5(); ex_br = 1;
        @(negedge clk);
        chk("br_flush", int'(o_ifid_flush), 1);
        chk("br_pc_en", int'(o_pc_en), 1);
        cyc();
        idle();
        @(negedge clk);
        chk("br_flush_cnt", int'(o_flush_count), 1);
        chk("br_stall_cnt", int'(o_stall_cycles), 1);
        cyc();

        mem_req = 1; mem_ready = 0;
        cyc();
        @(negedge clk);
        chk("mw_state", int'(o_state), 1);
        cyc(); cyc();
        mem_ready = 1;
        @(negedge clk);
        chk("mw_release", int'(o_pc_en), 1);
        cyc();
        idle();
        @(negedge clk);
        chk("mw_state_back", int'(o_state), 0);
        chk("mw_stall_cnt", int'(o_stall_cycles), 4);
        cyc();

        ex_br = 1;
        repeat (20) cyc();
        ex_br = 0;
        @(negedge clk);
        chk("flush_sat", int'(o_flush_count), CMAX);
        cyc();

        repeat (600) begin
            rst_n = ($urandom_range(0, 99) != 0);
            id_rs1_sel = 5'($urandom_range(0, 3));
            id_rs2_sel = 5'($urandom_range(0, 3));
            ex_rd_sel = 5'($urandom_range(0, 3));
            id_uses_rs1 = 1'($urandom_range(0, 1));
            id_uses_rs2 = 1'($urandom_range(0, 1));
            ex_we = 1'($urandom_range(0, 1));
            ex_ld = 1'($urandom_range(0, 1));
            ex_br = ($urandom_range(0, 3) == 0);
            mem_req = ($urandom_range(0, 2) == 0);
            mem_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end

        idle();
        rst_n = 0;
        cyc();
        rst_n = 1;
        mem_req = 1; mem_ready = 0;
        repeat (WAIT_MAX) cyc();
        @(negedge clk);
        chk("to_state", int'(o_state), 2);
        chk("to_trap", int'(o_trap), 1);
        chk("to_stall_sat", int'(o_stall_cycles), CMAX);
        mem_ready = 1;
        repeat (3) cyc();
        @(negedge clk);
        chk("trap_hold", int'(o_state), 2);
        cyc();
        rst_n = 0;
        #2;
        chk("arst_state", int'(o_state), 0);
        chk("arst_trap", int'(o_trap), 0);
        chk("arst_stall", int'(o_stall_cycles), 0);
        chk("arst_pc_en", int'(o_pc_en), 0);
        cyc();
        rst_n = 1;
        idle();
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
